// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Pure declarations: no logic, no latency, no flow control.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_RESP
    } lsu_state_e;

    localparam int MEM_BYTES = 1024;
    localparam int LANE_W    = 2;

endpackage

// File: rtl/byte_lane_unit.sv
// Byte-lane extract (sign/zero extend) and byte merge for a little-endian word.
// Purely combinational, zero latency, no flow control.
module byte_lane_unit
    import lsu_pkg::*;
(
    input  logic [31:0]       i_word,
    input  logic [LANE_W-1:0] i_lane,
    input  logic              i_signed,
    input  logic [7:0]        i_byte,
    output logic [31:0]       o_ext_dat,
    output logic [31:0]       o_merge_dat
);

    function automatic logic [31:0] lane_extract(input logic [31:0]       word,
                                                 input logic [LANE_W-1:0] lane,
                                                 input logic              sgn);
        logic [7:0] b;
        b = word[{lane, 3'b000} +: 8];
        return {{24{sgn & b[7]}}, b};
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0]       word,
                                               input logic [LANE_W-1:0] lane,
                                               input logic [7:0]        b);
        logic [31:0] w;
        w = word;
        w[{lane, 3'b000} +: 8] = b;
        return w;
    endfunction

    assign o_ext_dat   = lane_extract(i_word, i_lane, i_signed);
    assign o_merge_dat = lane_merge(i_word, i_lane, i_byte);

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer to word memory with byte extract and byte-store RMW; one request in flight.
// Response after 1 (error), 2 (word store), L+1 (load), L+2 (byte store) cycles; holds response until i_resp_ready.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_LATENCY   = 1,
    parameter int MAX_WORD_ADDR = MEM_BYTES - 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic        i_req_byte,
    input  logic        i_req_signed,
    input  logic [17:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_error,
    output logic [17:0] o_mem_address,
    output logic [31:0] o_mem_write_data,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic        o_mem_byte,
    input  logic [31:0] i_mem_read_data
);

    localparam logic [3:0]  LAT_INIT = 4'(MEM_LATENCY - 1);
    localparam logic [17:0] MAX_ADDR = 18'(MAX_WORD_ADDR);

    lsu_state_e        r_state;
    lsu_state_e        w_state_nxt;
    logic [3:0]        r_lat_cnt;
    logic              r_write;
    logic              r_byte;
    logic              r_signed;
    logic [LANE_W-1:0] r_lane;
    logic [7:0]        r_wbyte;
    logic [17:0]       r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic [31:0]       r_resp_rdata;
    logic              r_resp_error;

    logic              w_accept;
    logic              w_err;
    logic              w_rd_done;
    logic [31:0]       w_ext_dat;
    logic [31:0]       w_merge_dat;

    assign w_accept  = (r_state == ST_IDLE) && i_req_valid;
    assign w_err     = ((i_req_addr[1:0] != 2'b00) && !i_req_byte) ||
                       ({i_req_addr[17:2], 2'b00} > MAX_ADDR);
    assign w_rd_done = (r_state == ST_RD) && (r_lat_cnt == 4'd0);

    byte_lane_unit u_lane (
        .i_word      (i_mem_read_data),
        .i_lane      (r_lane),
        .i_signed    (r_signed),
        .i_byte      (r_wbyte),
        .o_ext_dat   (w_ext_dat),
        .o_merge_dat (w_merge_dat)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (i_req_valid) begin
                    if (w_err)                         w_state_nxt = ST_RESP;
                    else if (!i_req_write || i_req_byte) w_state_nxt = ST_RD;
                    else                               w_state_nxt = ST_WR;
                end
            end
            // Only byte stores pass through RD with r_write set.
            ST_RD:   if (w_rd_done) w_state_nxt = r_write ? ST_WR : ST_RESP;
            ST_WR:   w_state_nxt = ST_RESP;
            ST_RESP: if (i_resp_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lat_cnt    <= '0;
            r_write      <= 1'b0;
            r_byte       <= 1'b0;
            r_signed     <= 1'b0;
            r_lane       <= '0;
            r_wbyte      <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_resp_rdata <= '0;
            r_resp_error <= 1'b0;
        end else begin
            if (w_accept) begin
                r_lat_cnt    <= LAT_INIT;
                r_write      <= i_req_write;
                r_byte       <= i_req_byte;
                r_signed     <= i_req_signed;
                r_lane       <= i_req_addr[1:0];
                r_wbyte      <= i_req_wdata[7:0];
                r_mem_addr   <= {i_req_addr[17:2], 2'b00};
                r_mem_wdata  <= i_req_wdata;
                r_resp_rdata <= '0;
                r_resp_error <= w_err;
            end
            if (r_state == ST_RD) begin
                r_lat_cnt <= r_lat_cnt - 4'd1;
                if (r_lat_cnt == 4'd0) begin
                    if (r_write) r_mem_wdata  <= w_merge_dat;
                    else         r_resp_rdata <= r_byte ? w_ext_dat : i_mem_read_data;
                end
            end
        end
    end

    // Strobes decode straight from state so an async reset drops them at once.
    assign o_mem_read       = (r_state == ST_RD);
    assign o_mem_write      = (r_state == ST_WR);
    assign o_mem_byte       = 1'b0;
    assign o_mem_address    = r_mem_addr;
    assign o_mem_write_data = r_mem_wdata;
    assign o_req_ready      = (r_state == ST_IDLE);
    assign o_resp_valid     = (r_state == ST_RESP);
    assign o_resp_rdata     = r_resp_rdata;
    assign o_resp_error     = r_resp_error;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: one instance at MEM_LATENCY=1, one at 3, each with a word-array memory model.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic        req_valid, req_write, req_byte, req_signed, resp_ready;
    logic [17:0] req_addr;
    logic [31:0] req_wdata;

    logic        req_ready1, resp_valid1, resp_error1, mem_read1, mem_write1, mem_byte1;
    logic [31:0] resp_rdata1, mem_write_data1, mem_read_data1;
    logic [17:0] mem_address1;
    logic        req_ready3, resp_valid3, resp_error3, mem_read3, mem_write3, mem_byte3;
    logic [31:0] resp_rdata3, mem_write_data3, mem_read_data3;
    logic [17:0] mem_address3;

    logic [31:0] mem1 [256];
    logic [31:0] mem3 [256];

    int n_tests = 0;
    int n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    load_store_unit #(.MEM_LATENCY(1), .MAX_WORD_ADDR(1020)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid & ~sel), .o_req_ready(req_ready1),
        .i_req_write(req_write), .i_req_byte(req_byte), .i_req_signed(req_signed),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_resp_valid(resp_valid1), .i_resp_ready(resp_ready),
        .o_resp_rdata(resp_rdata1), .o_resp_error(resp_error1),
        .o_mem_address(mem_address1), .o_mem_write_data(mem_write_data1),
        .o_mem_read(mem_read1), .o_mem_write(mem_write1), .o_mem_byte(mem_byte1),
        .i_mem_read_data(mem_read_data1)
    );

    load_store_unit #(.MEM_LATENCY(3), .MAX_WORD_ADDR(1020)) u_dut3 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid & sel), .o_req_ready(req_ready3),
        .i_req_write(req_write), .i_req_byte(req_byte), .i_req_signed(req_signed),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_resp_valid(resp_valid3), .i_resp_ready(resp_ready),
        .o_resp_rdata(resp_rdata3), .o_resp_error(resp_error3),
        .o_mem_address(mem_address3), .o_mem_write_data(mem_write_data3),
        .o_mem_read(mem_read3), .o_mem_write(mem_write3), .o_mem_byte(mem_byte3),
        .i_mem_read_data(mem_read_data3)
    );

    assign mem_read_data1 = mem1[mem_address1[9:2]];
    assign mem_read_data3 = mem3[mem_address3[9:2]];
    always @(posedge clk) if (mem_write1) mem1[mem_address1[9:2]] <= mem_write_data1;
    always @(posedge clk) if (mem_write3) mem3[mem_address3[9:2]] <= mem_write_data3;

    logic        m_req_ready, m_resp_valid, m_resp_error, m_mem_read, m_mem_write;
    logic [31:0] m_resp_rdata;
    logic [17:0] m_mem_address;
    assign m_req_ready   = sel ? req_ready3   : req_ready1;
    assign m_resp_valid  = sel ? resp_valid3  : resp_valid1;
    assign m_resp_error  = sel ? resp_error3  : resp_error1;
    assign m_mem_read    = sel ? mem_read3    : mem_read1;
    assign m_mem_write   = sel ? mem_write3   : mem_write1;
    assign m_resp_rdata  = sel ? resp_rdata3  : resp_rdata1;
    assign m_mem_address = sel ? mem_address3 : mem_address1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        s;
        logic        wr;
        logic        byt;
        logic        sg;
        logic [17:0] a;
        logic [31:0] wd;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s, input logic wr, input logic byt, input logic sg,
                                input logic [17:0] a, input logic [31:0] wd, input int hold,
                                input logic [31:0] er, input logic ee, input int lat,
                                input int nrd, input int nwr);
        vec_t v;
        v.s = s; v.wr = wr; v.byt = byt; v.sg = sg; v.a = a; v.wd = wd; v.hold = hold;
        v.exp_rdata = er; v.exp_err = ee; v.exp_lat = lat; v.exp_rd = nrd; v.exp_wr = nwr;
        return v;
    endfunction

    // One full transaction: issue, watch strobes until the response, optionally stall it, then retire it.
    task automatic xact(input vec_t v, output logic [31:0] rdata, output logic err,
                        output int lat, output int nrd, output int nwr);
        int   cyc;
        logic [17:0] base;
        base = {v.a[17:2], 2'b00};
        @(negedge clk);
        sel = v.s; req_write = v.wr; req_byte = v.byt; req_signed = v.sg;
        req_addr = v.a; req_wdata = v.wd; req_valid = 1'b1;
        resp_ready = (v.hold == 0);
        check("req_ready_idle", 32'(m_req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1; nrd = 0; nwr = 0; lat = -1;
        while (cyc < 40) begin
            if (m_mem_read)  nrd++;
            if (m_mem_write) nwr++;
            if (m_mem_read || m_mem_write) begin
                check("strobe_exclusive", 32'(m_mem_read & m_mem_write), 32'd0);
                check("mem_address", 32'(m_mem_address), 32'(base));
            end
            if (m_resp_valid) begin
                lat = cyc;
                break;
            end
            cyc++;
            @(negedge clk);
        end
        if (lat < 0) begin
            n_tests++; n_fail++;
            $display("FAIL resp_timeout: got no resp_valid, expected one within 40 cycles");
        end
        rdata = m_resp_rdata;
        err   = m_resp_error;
        check("req_ready_busy", 32'(m_req_ready), 32'd0);
        for (int i = 1; i <= v.hold; i++) begin
            @(negedge clk);
            check("hold_resp_valid", 32'(m_resp_valid), 32'd1);
            check("hold_rdata", m_resp_rdata, rdata);
            check("hold_error", 32'(m_resp_error), 32'(err));
            check("hold_no_read", 32'(m_mem_read), 32'd0);
            if (i == v.hold) resp_ready = 1'b1;
        end
        @(negedge clk);
        check("req_ready_after", 32'(m_req_ready), 32'd1);
        check("resp_valid_after", 32'(m_resp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200us");
        $fatal(1);
    end

    initial begin
        logic [31:0] rdata;
        logic        err;
        int          lat, nrd, nwr, nbad;

        rst_n = 1'b0; sel = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;

        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check("rst_req_ready", 32'(m_req_ready), 32'd1);
            check("rst_resp_valid", 32'(m_resp_valid), 32'd0);
            check("rst_resp_error", 32'(m_resp_error), 32'd0);
            check("rst_resp_rdata", m_resp_rdata, 32'd0);
            check("rst_strobes", 32'({m_mem_read, m_mem_write}), 32'd0);
            check("rst_mem_address", 32'(m_mem_address), 32'd0);
        end
        check("rst_wdata1", mem_write_data1, 32'd0);
        check("rst_wdata3", mem_write_data3, 32'd0);
        check("mem_byte", 32'({mem_byte1, mem_byte3}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //              s   wr  byt sg  addr       wdata          hold rdata          err lat rd wr
        vecs.push_back(mk(0, 1, 0, 0, 18'h010, 32'hDEADBEEF, 0, 32'h00000000, 0, 2, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 18'h010, 32'h0,        0, 32'hDEADBEEF, 0, 2, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 18'h010, 32'h11223344, 0, 32'h00000000, 0, 2, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 18'h013, 32'hAAAAAA7F, 0, 32'h00000000, 0, 3, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 18'h010, 32'h0,        0, 32'h7F223344, 0, 2, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 18'h010, 32'h00A50000, 0, 32'h00000000, 0, 2, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 18'h012, 32'h0,        0, 32'hFFFFFFA5, 0, 2, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 18'h012, 32'h0,        0, 32'h000000A5, 0, 2, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 18'h010, 32'h00000080, 0, 32'h00000000, 0, 3, 1, 1));
        vecs.push_back(mk(0, 0, 1, 1, 18'h010, 32'h0,        0, 32'hFFFFFF80, 0, 2, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 18'h010, 32'h0,        0, 32'h00A50080, 0, 2, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 18'h006, 32'h0,        0, 32'h00000000, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 18'h400, 32'h0,        0, 32'h00000000, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 18'h3FE, 32'h12345678, 0, 32'h00000000, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 18'h401, 32'h000000FF, 0, 32'h00000000, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 18'h3FC, 32'h80000000, 0, 32'h00000000, 0, 2, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 18'h3FF, 32'h0,        0, 32'hFFFFFF80, 0, 2, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 18'h020, 32'hCAFEF00D, 0, 32'h00000000, 0, 2, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 18'h020, 32'h0,        4, 32'hCAFEF00D, 0, 4, 3, 0));
        vecs.push_back(mk(1, 1, 1, 0, 18'h021, 32'h00000055, 0, 32'h00000000, 0, 5, 3, 1));
        vecs.push_back(mk(1, 0, 0, 0, 18'h020, 32'h0,        0, 32'hCAFE550D, 0, 4, 3, 0));
        vecs.push_back(mk(1, 0, 1, 0, 18'h022, 32'h0,        2, 32'h000000FE, 0, 4, 3, 0));
        vecs.push_back(mk(1, 1, 0, 0, 18'h030, 32'h12345678, 0, 32'h00000000, 0, 2, 0, 1));

        foreach (vecs[k]) begin
            xact(vecs[k], rdata, err, lat, nrd, nwr);
            check($sformatf("v%0d_rdata", k), rdata, vecs[k].exp_rdata);
            check($sformatf("v%0d_error", k), 32'(err), 32'(vecs[k].exp_err));
            check($sformatf("v%0d_latency", k), 32'(lat), 32'(vecs[k].exp_lat));
            check($sformatf("v%0d_reads", k), 32'(nrd), 32'(vecs[k].exp_rd));
            check($sformatf("v%0d_writes", k), 32'(nwr), 32'(vecs[k].exp_wr));
        end

        // Reset during the read phase of a byte store on the 3-cycle instance.
        @(negedge clk);
        sel = 1'b1; req_write = 1'b1; req_byte = 1'b1; req_signed = 1'b0;
        req_addr = 18'h031; req_wdata = 32'h000000EE; req_valid = 1'b1; resp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("rmw_rd_started", 32'(mem_read3), 32'd1);
        @(negedge clk);
        check("rmw_rd_cycle2", 32'(mem_read3), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_strobes", 32'({mem_read3, mem_write3}), 32'd0);
        check("arst_resp_valid", 32'(resp_valid3), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nbad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_valid3 || mem_write3 || mem_read3) nbad++;
        end
        check("arst_no_activity", 32'(nbad), 32'd0);
        check("arst_req_ready", 32'(req_ready3), 32'd1);
        check("arst_mem_unchanged", mem3[12], 32'h12345678);
        xact(mk(1, 0, 0, 0, 18'h030, 32'h0, 0, 32'h0, 0, 4, 3, 0), rdata, err, lat, nrd, nwr);
        check("arst_reload", rdata, 32'h12345678);
        check("arst_reload_err", 32'(err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
